// File: rtl/seq_pkg.sv
// -----------------------------------------------------------------------------
// seq_pkg
// Shared definitions for the hardwired control sequencer:
//   - seq_state_t  : 4-bit binary state encoding (IDLE, T0..T7, HALT)
//   - op_class_t   : instruction class produced by opcode decode
//   - opcode and ALU operation constants
//   - IR register-field positions used by the datapath selects
//   - classify()   : maps an opcode onto its instruction class
// -----------------------------------------------------------------------------
package seq_pkg;

    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_T0   = 4'd1,
        ST_T1   = 4'd2,
        ST_T2   = 4'd3,
        ST_T3   = 4'd4,
        ST_T4   = 4'd5,
        ST_T5   = 4'd6,
        ST_T6   = 4'd7,
        ST_T7   = 4'd8,
        ST_HALT = 4'd9
    } seq_state_t;

    typedef enum logic [2:0] {
        CLS_RTYPE,
        CLS_ITYPE,
        CLS_LD,
        CLS_ST,
        CLS_HALT,
        CLS_ILLEGAL
    } op_class_t;

    // Opcodes 0x00..OP_RTYPE_LAST are R-type; the opcode doubles as ALU select.
    localparam logic [7:0] OP_RTYPE_LAST = 8'h0A;
    localparam logic [7:0] OP_ADDI       = 8'h0B;
    localparam logic [7:0] OP_ANDI       = 8'h0C;
    localparam logic [7:0] OP_ORI        = 8'h0D;
    localparam logic [7:0] OP_LD         = 8'h0E;
    localparam logic [7:0] OP_ST         = 8'h0F;
    localparam logic [7:0] OP_HALT       = 8'h1F;

    localparam logic [4:0] ALU_ADD = 5'h00;
    localparam logic [4:0] ALU_AND = 5'h05;
    localparam logic [4:0] ALU_OR  = 5'h06;

    // Register fields inside IR, decoded by the datapath when G_RA/G_RB/G_RC fire.
    localparam int RA_HI = 26;
    localparam int RA_LO = 23;
    localparam int RB_HI = 22;
    localparam int RB_LO = 19;
    localparam int RC_HI = 18;
    localparam int RC_LO = 15;

    function automatic op_class_t classify(input logic [7:0] op);
        if (op <= OP_RTYPE_LAST)
            return CLS_RTYPE;
        else if (op == OP_ADDI || op == OP_ANDI || op == OP_ORI)
            return CLS_ITYPE;
        else if (op == OP_LD)
            return CLS_LD;
        else if (op == OP_ST)
            return CLS_ST;
        else if (op == OP_HALT)
            return CLS_HALT;
        else
            return CLS_ILLEGAL;
    endfunction

endpackage

// File: rtl/seq_wait_timer.sv
// -----------------------------------------------------------------------------
// seq_wait_timer
// Counts cycles the sequencer has spent stalled in a memory wait state and
// flags a timeout on the MEM_WAIT_MAX-th stalled cycle.
// Ports:
//   clk        in  system clock, rising edge
//   rst        in  asynchronous active-high reset
//   in_wait    in  sequencer is currently in a memory wait state
//   mem_ready  in  memory completed the access this cycle
//   timeout    out this stalled cycle is the last one allowed
// -----------------------------------------------------------------------------
module seq_wait_timer #(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic in_wait,
    input  logic mem_ready,
    output logic timeout
);

    logic [7:0] wait_cnt;
    logic       stalled;

    assign stalled = in_wait && !mem_ready;

    // wait_cnt holds the number of stalled cycles already spent in the current
    // wait state; any non-stalled cycle (including leaving the state) clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            wait_cnt <= '0;
        else if (stalled)
            wait_cnt <= wait_cnt + 8'd1;
        else
            wait_cnt <= '0;
    end

    assign timeout = stalled && (wait_cnt >= 8'(MEM_WAIT_MAX - 1));

endmodule

// File: rtl/control_sequencer.sv
// -----------------------------------------------------------------------------
// control_sequencer
// Hardwired Moore control unit: fetches via PC/MAR/MDR/IR, decodes IR opcode,
// and steps T-states that drive the datapath strobes for R-type, I-type,
// load and store instructions, with memory-wait timeout and run/halt control.
//
// Optional build macro SEQ_SINGLE_STEP_EN adds the Step input: with Step=1
// every instruction returns to IDLE, and IDLE is left only on a Run rising edge.
//
// Ports:
//   Clock, Clear           clock (rising) and asynchronous active-high reset
//   Run                    start/continue execution (level)
//   Mem_Ready              memory finished the current Read/Write
//   Step                   single-step request (SEQ_SINGLE_STEP_EN only)
//   IR[31:0]               instruction register contents
//   CONTROL[CTRL_W-1:0]    ALU operation select (non-zero only in T4)
//   IncPC, Read, Write     PC increment, memory read, memory write
//   PC_Out..R_Out          bus drivers
//   PC_In..R_In            register loads
//   G_RA, G_RB, G_RC       register-field selects
//   Halted                 sequencer is in HALT
//   Mem_Fault              sticky memory-timeout flag
//   Illegal_Op             one-cycle pulse on an undefined opcode
// -----------------------------------------------------------------------------
module control_sequencer
    import seq_pkg::*;
#(
    parameter int OPW          = 5,
    parameter int CTRL_W       = 5,
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic              Clock,
    input  logic              Clear,
    input  logic              Run,
    input  logic              Mem_Ready,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic              Step,
`endif
    input  logic [31:0]       IR,
    output logic [CTRL_W-1:0] CONTROL,
    output logic              IncPC,
    output logic              Read,
    output logic              Write,
    output logic              PC_Out,
    output logic              MDR_Out,
    output logic              ZLO_Out,
    output logic              C_Out,
    output logic              BA_Out,
    output logic              R_Out,
    output logic              PC_In,
    output logic              MDR_In,
    output logic              MAR_In,
    output logic              IR_In,
    output logic              Y_In,
    output logic              ZLO_In,
    output logic              R_In,
    output logic              G_RA,
    output logic              G_RB,
    output logic              G_RC,
    output logic              Halted,
    output logic              Mem_Fault,
    output logic              Illegal_Op
);

    seq_state_t        state;
    seq_state_t        state_next;
    seq_state_t        return_state;
    op_class_t         op_class;
    logic [OPW-1:0]    opcode;
    logic [CTRL_W-1:0] alu_sel;
    logic              in_wait;
    logic              timeout;
    logic              start_ok;
    logic              ir_unused;

    assign opcode    = IR[31 -: OPW];
    assign ir_unused = ^IR[31-OPW:0];
    assign op_class  = classify(8'(opcode));

    // Only the fetch read, the load read and the store write can stall.
    assign in_wait = (state == ST_T1)
                  || (state == ST_T6 && op_class == CLS_LD)
                  || (state == ST_T7 && op_class == CLS_ST);

    seq_wait_timer #(
        .MEM_WAIT_MAX (MEM_WAIT_MAX)
    ) u_wait_timer (
        .clk       (Clock),
        .rst       (Clear),
        .in_wait   (in_wait),
        .mem_ready (Mem_Ready),
        .timeout   (timeout)
    );

`ifdef SEQ_SINGLE_STEP_EN
    logic run_q;

    // Registered Run lets IDLE wait for a fresh Run edge while single-stepping.
    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear)
            run_q <= 1'b0;
        else
            run_q <= Run;
    end

    assign start_ok     = Step ? (Run && !run_q) : Run;
    assign return_state = (Run && !Step) ? ST_T0 : ST_IDLE;
`else
    assign start_ok     = Run;
    assign return_state = Run ? ST_T0 : ST_IDLE;
`endif

    // State register; Clear forces IDLE at any time, mid-wait included.
    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    // Memory-timeout flag stays set until the next Clear.
    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear)
            Mem_Fault <= 1'b0;
        else if (timeout)
            Mem_Fault <= 1'b1;
    end

    // Next-state logic. Run is only consulted at IDLE and at the end of an
    // instruction, so dropping Run mid-instruction lets it complete.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start_ok) state_next = ST_T0;
            ST_T0:   state_next = ST_T1;
            ST_T1: begin
                if (timeout)
                    state_next = ST_HALT;
                else if (Mem_Ready)
                    state_next = ST_T2;
            end
            ST_T2:   state_next = ST_T3;
            ST_T3: begin
                case (op_class)
                    CLS_HALT:    state_next = ST_HALT;
                    CLS_ILLEGAL: state_next = return_state;
                    default:     state_next = ST_T4;
                endcase
            end
            ST_T4:   state_next = ST_T5;
            ST_T5: begin
                if (op_class == CLS_LD || op_class == CLS_ST)
                    state_next = ST_T6;
                else
                    state_next = return_state;
            end
            ST_T6: begin
                if (op_class != CLS_LD)
                    state_next = ST_T7;
                else if (timeout)
                    state_next = ST_HALT;
                else if (Mem_Ready)
                    state_next = ST_T7;
            end
            ST_T7: begin
                if (op_class != CLS_ST)
                    state_next = return_state;
                else if (timeout)
                    state_next = ST_HALT;
                else if (Mem_Ready)
                    state_next = return_state;
            end
            ST_HALT: state_next = ST_HALT;
            default: state_next = ST_IDLE;
        endcase
    end

    // ALU select for T4: R-type passes the opcode through, I-type and
    // load/store address generation map onto fixed ALU codes.
    always_comb begin
        alu_sel = '0;
        case (op_class)
            CLS_RTYPE: alu_sel = CTRL_W'(opcode);
            CLS_ITYPE: begin
                if (8'(opcode) == OP_ANDI)
                    alu_sel = CTRL_W'(ALU_AND);
                else if (8'(opcode) == OP_ORI)
                    alu_sel = CTRL_W'(ALU_OR);
                else
                    alu_sel = CTRL_W'(ALU_ADD);
            end
            default:   alu_sel = CTRL_W'(ALU_ADD);
        endcase
    end

    // Output decode from the state register and the held IR class.
    always_comb begin
        CONTROL    = '0;
        IncPC      = 1'b0;
        Read       = 1'b0;
        Write      = 1'b0;
        PC_Out     = 1'b0;
        MDR_Out    = 1'b0;
        ZLO_Out    = 1'b0;
        C_Out      = 1'b0;
        BA_Out     = 1'b0;
        R_Out      = 1'b0;
        PC_In      = 1'b0;
        MDR_In     = 1'b0;
        MAR_In     = 1'b0;
        IR_In      = 1'b0;
        Y_In       = 1'b0;
        ZLO_In     = 1'b0;
        R_In       = 1'b0;
        G_RA       = 1'b0;
        G_RB       = 1'b0;
        G_RC       = 1'b0;
        Halted     = 1'b0;
        Illegal_Op = 1'b0;
        case (state)
            ST_T0: begin
                PC_Out = 1'b1;
                MAR_In = 1'b1;
                IncPC  = 1'b1;
            end
            ST_T1: begin
                Read   = 1'b1;
                MDR_In = 1'b1;
            end
            ST_T2: begin
                MDR_Out = 1'b1;
                IR_In   = 1'b1;
            end
            ST_T3: begin
                case (op_class)
                    CLS_RTYPE: begin
                        G_RB  = 1'b1;
                        R_Out = 1'b1;
                        Y_In  = 1'b1;
                    end
                    CLS_ITYPE, CLS_LD, CLS_ST: begin
                        G_RB   = 1'b1;
                        BA_Out = 1'b1;
                        Y_In   = 1'b1;
                    end
                    CLS_ILLEGAL: Illegal_Op = 1'b1;
                    default: ;
                endcase
            end
            ST_T4: begin
                CONTROL = alu_sel;
                ZLO_In  = 1'b1;
                if (op_class == CLS_RTYPE) begin
                    G_RC  = 1'b1;
                    R_Out = 1'b1;
                end else begin
                    C_Out = 1'b1;
                end
            end
            ST_T5: begin
                ZLO_Out = 1'b1;
                if (op_class == CLS_LD || op_class == CLS_ST) begin
                    MAR_In = 1'b1;
                end else begin
                    G_RA = 1'b1;
                    R_In = 1'b1;
                end
            end
            ST_T6: begin
                MDR_In = 1'b1;
                if (op_class == CLS_LD) begin
                    Read = 1'b1;
                end else begin
                    G_RA  = 1'b1;
                    R_Out = 1'b1;
                end
            end
            ST_T7: begin
                if (op_class == CLS_LD) begin
                    MDR_Out = 1'b1;
                    G_RA    = 1'b1;
                    R_In    = 1'b1;
                end else begin
                    Write = 1'b1;
                end
            end
            ST_HALT: Halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_control_sequencer
// Directed sequences with literal expectations, then randomized instruction
// streams compared every cycle against a micro-program queue model.
// -----------------------------------------------------------------------------
module tb_control_sequencer;

    localparam int MEM_WAIT_MAX = 15;

    // Bit positions of the packed strobe word used for comparison.
    localparam int B_INCPC  = 20;
    localparam int B_READ   = 19;
    localparam int B_WRITE  = 18;
    localparam int B_PCOUT  = 17;
    localparam int B_MDROUT = 16;
    localparam int B_ZLOOUT = 15;
    localparam int B_COUT   = 14;
    localparam int B_BAOUT  = 13;
    localparam int B_ROUT   = 12;
    localparam int B_PCIN   = 11;
    localparam int B_MDRIN  = 10;
    localparam int B_MARIN  = 9;
    localparam int B_IRIN   = 8;
    localparam int B_YIN    = 7;
    localparam int B_ZLOIN  = 6;
    localparam int B_RIN    = 5;
    localparam int B_GRA    = 4;
    localparam int B_GRB    = 3;
    localparam int B_GRC    = 2;
    localparam int B_HALTED = 1;
    localparam int B_ILL    = 0;

    localparam logic [20:0] S_INCPC  = 21'h1 << B_INCPC;
    localparam logic [20:0] S_READ   = 21'h1 << B_READ;
    localparam logic [20:0] S_WRITE  = 21'h1 << B_WRITE;
    localparam logic [20:0] S_PCOUT  = 21'h1 << B_PCOUT;
    localparam logic [20:0] S_MDROUT = 21'h1 << B_MDROUT;
    localparam logic [20:0] S_ZLOOUT = 21'h1 << B_ZLOOUT;
    localparam logic [20:0] S_COUT   = 21'h1 << B_COUT;
    localparam logic [20:0] S_BAOUT  = 21'h1 << B_BAOUT;
    localparam logic [20:0] S_ROUT   = 21'h1 << B_ROUT;
    localparam logic [20:0] S_MDRIN  = 21'h1 << B_MDRIN;
    localparam logic [20:0] S_MARIN  = 21'h1 << B_MARIN;
    localparam logic [20:0] S_IRIN   = 21'h1 << B_IRIN;
    localparam logic [20:0] S_YIN    = 21'h1 << B_YIN;
    localparam logic [20:0] S_ZLOIN  = 21'h1 << B_ZLOIN;
    localparam logic [20:0] S_RIN    = 21'h1 << B_RIN;
    localparam logic [20:0] S_GRA    = 21'h1 << B_GRA;
    localparam logic [20:0] S_GRB    = 21'h1 << B_GRB;
    localparam logic [20:0] S_GRC    = 21'h1 << B_GRC;
    localparam logic [20:0] S_HALTED = 21'h1 << B_HALTED;
    localparam logic [20:0] S_ILL    = 21'h1 << B_ILL;

    localparam logic [20:0] W_FETCH0 = S_INCPC | S_PCOUT | S_MARIN;
    localparam logic [20:0] W_FETCH1 = S_READ | S_MDRIN;
    localparam logic [20:0] W_FETCH2 = S_MDROUT | S_IRIN;

    logic        Clock = 1'b0;
    logic        Clear;
    logic        Run;
    logic        Mem_Ready;
    logic [31:0] IR;
    logic [4:0]  CONTROL;
    logic        IncPC, Read, Write;
    logic        PC_Out, MDR_Out, ZLO_Out, C_Out, BA_Out, R_Out;
    logic        PC_In, MDR_In, MAR_In, IR_In, Y_In, ZLO_In, R_In;
    logic        G_RA, G_RB, G_RC;
    logic        Halted, Mem_Fault, Illegal_Op;
    logic [20:0] dut_word;

    control_sequencer #(
        .OPW          (5),
        .CTRL_W       (5),
        .MEM_WAIT_MAX (MEM_WAIT_MAX)
    ) dut (
        .Clock      (Clock),
        .Clear      (Clear),
        .Run        (Run),
        .Mem_Ready  (Mem_Ready),
        .IR         (IR),
        .CONTROL    (CONTROL),
        .IncPC      (IncPC),
        .Read       (Read),
        .Write      (Write),
        .PC_Out     (PC_Out),
        .MDR_Out    (MDR_Out),
        .ZLO_Out    (ZLO_Out),
        .C_Out      (C_Out),
        .BA_Out     (BA_Out),
        .R_Out      (R_Out),
        .PC_In      (PC_In),
        .MDR_In     (MDR_In),
        .MAR_In     (MAR_In),
        .IR_In      (IR_In),
        .Y_In       (Y_In),
        .ZLO_In     (ZLO_In),
        .R_In       (R_In),
        .G_RA       (G_RA),
        .G_RB       (G_RB),
        .G_RC       (G_RC),
        .Halted     (Halted),
        .Mem_Fault  (Mem_Fault),
        .Illegal_Op (Illegal_Op)
    );

    always #5 Clock = ~Clock;

    assign dut_word = {IncPC, Read, Write, PC_Out, MDR_Out, ZLO_Out, C_Out,
                       BA_Out, R_Out, PC_In, MDR_In, MAR_In, IR_In, Y_In,
                       ZLO_In, R_In, G_RA, G_RB, G_RC, Halted, Illegal_Op};

    int checks = 0;
    int errors = 0;

    // Model: the remaining micro-steps of the current instruction as a queue.
    typedef struct packed {
        logic [20:0] strobes;
        logic [4:0]  ctrl;
        logic        waits;
        logic        decode;
        logic        halt_after;
    } uop_t;

    typedef enum {M_IDLE, M_RUN, M_HALT} mode_t;

    uop_t  prog[$];
    mode_t mode;
    int    wait_count;
    bit    fault;
    int    stuck_count = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        @(negedge Clock);
    endtask

    function automatic uop_t mk_uop(input logic [20:0] s, input logic [4:0] c,
                                    input logic w, input logic d, input logic h);
        uop_t u;
        u.strobes    = s;
        u.ctrl       = c;
        u.waits      = w;
        u.decode     = d;
        u.halt_after = h;
        return u;
    endfunction

    task automatic load_fetch();
        prog.delete();
        prog.push_back(mk_uop(W_FETCH0, 5'h0, 1'b0, 1'b0, 1'b0));
        prog.push_back(mk_uop(W_FETCH1, 5'h0, 1'b1, 1'b0, 1'b0));
        prog.push_back(mk_uop(W_FETCH2, 5'h0, 1'b0, 1'b1, 1'b0));
    endtask

    task automatic push_class(input logic [4:0] op);
        logic [20:0] i3, i4, wb;
        i3 = S_GRB | S_BAOUT | S_YIN;
        i4 = S_COUT | S_ZLOIN;
        wb = S_ZLOOUT | S_GRA | S_RIN;
        if (op <= 5'h0A) begin
            prog.push_back(mk_uop(S_GRB | S_ROUT | S_YIN, 5'h0, 1'b0, 1'b0, 1'b0));
            prog.push_back(mk_uop(S_GRC | S_ROUT | S_ZLOIN, op, 1'b0, 1'b0, 1'b0));
            prog.push_back(mk_uop(wb, 5'h0, 1'b0, 1'b0, 1'b0));
        end else if (op >= 5'h0B && op <= 5'h0D) begin
            prog.push_back(mk_uop(i3, 5'h0, 1'b0, 1'b0, 1'b0));
            prog.push_back(mk_uop(i4, (op == 5'h0B) ? 5'h00 : (op == 5'h0C) ? 5'h05 : 5'h06,
                                  1'b0, 1'b0, 1'b0));
            prog.push_back(mk_uop(wb, 5'h0, 1'b0, 1'b0, 1'b0));
        end else if (op == 5'h0E || op == 5'h0F) begin
            prog.push_back(mk_uop(i3, 5'h0, 1'b0, 1'b0, 1'b0));
            prog.push_back(mk_uop(i4, 5'h0, 1'b0, 1'b0, 1'b0));
            prog.push_back(mk_uop(S_ZLOOUT | S_MARIN, 5'h0, 1'b0, 1'b0, 1'b0));
            if (op == 5'h0E) begin
                prog.push_back(mk_uop(S_READ | S_MDRIN, 5'h0, 1'b1, 1'b0, 1'b0));
                prog.push_back(mk_uop(S_MDROUT | S_GRA | S_RIN, 5'h0, 1'b0, 1'b0, 1'b0));
            end else begin
                prog.push_back(mk_uop(S_GRA | S_ROUT | S_MDRIN, 5'h0, 1'b0, 1'b0, 1'b0));
                prog.push_back(mk_uop(S_WRITE, 5'h0, 1'b1, 1'b0, 1'b0));
            end
        end else if (op == 5'h1F) begin
            prog.push_back(mk_uop(21'h0, 5'h0, 1'b0, 1'b0, 1'b1));
        end else begin
            prog.push_back(mk_uop(S_ILL, 5'h0, 1'b0, 1'b0, 1'b0));
        end
    endtask

    task automatic model_reset();
        mode       = M_IDLE;
        prog.delete();
        wait_count = 0;
        fault      = 1'b0;
    endtask

    // Advance the model by one clock edge using the inputs seen at that edge.
    task automatic model_step(input logic run, input logic ready);
        uop_t h;
        case (mode)
            M_IDLE: begin
                if (run) begin
                    load_fetch();
                    mode = M_RUN;
                end
            end
            M_RUN: begin
                h = prog[0];
                if (h.waits && !ready) begin
                    if (wait_count + 1 >= MEM_WAIT_MAX) begin
                        fault      = 1'b1;
                        mode       = M_HALT;
                        prog.delete();
                        wait_count = 0;
                    end else begin
                        wait_count++;
                    end
                end else begin
                    wait_count = 0;
                    void'(prog.pop_front());
                    if (h.halt_after) begin
                        mode = M_HALT;
                        prog.delete();
                    end else begin
                        if (h.decode)
                            push_class(IR[31:27]);
                        if (prog.size() == 0) begin
                            if (run)
                                load_fetch();
                            else
                                mode = M_IDLE;
                        end
                    end
                end
            end
            default: ;
        endcase
    endtask

    task automatic compare_model();
        logic [20:0] ew;
        logic [4:0]  ec;
        ew = 21'h0;
        ec = 5'h0;
        if (mode == M_HALT) begin
            ew = S_HALTED;
        end else if (mode == M_RUN) begin
            ew = prog[0].strobes;
            ec = prog[0].ctrl;
        end
        checkOutput("rand_strobes", 32'(dut_word), 32'(ew));
        checkOutput("rand_control", 32'(CONTROL), 32'(ec));
        checkOutput("rand_mem_fault", 32'(Mem_Fault), 32'(fault));
    endtask

    function automatic logic [31:0] random_instr();
        int unsigned r;
        logic [4:0]  op;
        r = $urandom_range(0, 19);
        if (r < 10)       op = 5'($urandom_range(0, 10));
        else if (r < 13)  op = 5'($urandom_range(11, 13));
        else if (r < 15)  op = 5'h0E;
        else if (r < 17)  op = 5'h0F;
        else if (r == 17) op = 5'h1F;
        else              op = 5'($urandom_range(16, 30));
        return {op, 27'($urandom)};
    endfunction

    task automatic applyStimulus();
        Clear = ($urandom_range(0, 299) == 0) ||
                (mode == M_HALT && $urandom_range(0, 7) == 0);
        Run   = ($urandom_range(0, 9) != 0);
        if (stuck_count > 0) begin
            Mem_Ready = 1'b0;
            stuck_count--;
        end else begin
            if ($urandom_range(0, 99) == 0)
                stuck_count = 20;
            Mem_Ready = ($urandom_range(0, 9) < 7);
        end
        // IR only changes while the fetch is loading it, as in the datapath.
        if (mode == M_RUN && prog[0].decode)
            IR = random_instr();
    endtask

    initial begin
        Clear     = 1'b1;
        Run       = 1'b0;
        Mem_Ready = 1'b1;
        IR        = 32'h0;
        @(negedge Clock);
        @(negedge Clock);
        checkOutput("reset_strobes", 32'(dut_word), 32'h0);
        checkOutput("reset_control", 32'(CONTROL), 32'h0);
        checkOutput("reset_fault", 32'(Mem_Fault), 32'h0);

        // addi 0x59087FFB with memory always ready
        Clear = 1'b0;
        Run   = 1'b1;
        IR    = 32'h59087FFB;
        tick(); checkOutput("addi_T0", 32'(dut_word), 32'(W_FETCH0));
        tick(); checkOutput("addi_T1", 32'(dut_word), 32'(W_FETCH1));
        tick(); checkOutput("addi_T2", 32'(dut_word), 32'(W_FETCH2));
        tick(); checkOutput("addi_T3", 32'(dut_word), 32'(S_GRB | S_BAOUT | S_YIN));
        tick(); checkOutput("addi_T4", 32'(dut_word), 32'(S_COUT | S_ZLOIN));
        checkOutput("addi_T4_ctrl", 32'(CONTROL), 32'h0);
        tick(); checkOutput("addi_T5", 32'(dut_word), 32'(S_ZLOOUT | S_GRA | S_RIN));
        tick(); checkOutput("addi_back_T0", 32'(dut_word), 32'(W_FETCH0));

        // R-type opcode 0x05
        IR = {5'h05, 27'h0123456};
        tick(); tick();
        tick(); checkOutput("r_T3", 32'(dut_word), 32'(S_GRB | S_ROUT | S_YIN));
        checkOutput("r_T3_ctrl", 32'(CONTROL), 32'h0);
        tick(); checkOutput("r_T4", 32'(dut_word), 32'(S_GRC | S_ROUT | S_ZLOIN));
        checkOutput("r_T4_ctrl", 32'(CONTROL), 32'h5);
        tick(); checkOutput("r_T5_ctrl", 32'(CONTROL), 32'h0);
        tick(); checkOutput("r_back_T0", 32'(dut_word), 32'(W_FETCH0));

        // ld with four stalled cycles in T6
        IR = {5'h0E, 27'h0};
        tick(); tick(); tick(); tick();
        tick(); checkOutput("ld_T5", 32'(dut_word), 32'(S_ZLOOUT | S_MARIN));
        Mem_Ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("ld_T6_hold", 32'(dut_word), 32'(S_READ | S_MDRIN));
            if (i == 4)
                Mem_Ready = 1'b1;
        end
        Run = 1'b0;
        tick(); checkOutput("ld_T7", 32'(dut_word), 32'(S_MDROUT | S_GRA | S_RIN));
        tick(); checkOutput("ld_return_idle", 32'(dut_word), 32'h0);

        // fetch with memory never ready
        Run       = 1'b1;
        Mem_Ready = 1'b0;
        tick(); checkOutput("stuck_T0", 32'(dut_word), 32'(W_FETCH0));
        for (int i = 0; i < MEM_WAIT_MAX; i++) begin
            tick();
            checkOutput("stuck_T1", 32'(dut_word), 32'(W_FETCH1));
        end
        checkOutput("stuck_no_fault_yet", 32'(Mem_Fault), 32'h0);
        tick(); checkOutput("stuck_halted", 32'(dut_word), 32'(S_HALTED));
        checkOutput("stuck_fault", 32'(Mem_Fault), 32'h1);
        Clear = 1'b1;
        #1;
        checkOutput("stuck_clear_outputs", 32'(dut_word), 32'h0);
        checkOutput("stuck_clear_fault", 32'(Mem_Fault), 32'h0);
        @(negedge Clock);
        Clear     = 1'b0;
        Mem_Ready = 1'b1;

        // illegal opcode 0x1A
        IR = {5'h1A, 27'h0};
        tick(); tick(); tick();
        tick(); checkOutput("illegal_T3", 32'(dut_word), 32'(S_ILL));
        tick(); checkOutput("illegal_then_T0", 32'(dut_word), 32'(W_FETCH0));

        // halt opcode 0x1F
        IR = {5'h1F, 27'h0};
        tick(); tick();
        tick(); checkOutput("halt_T3", 32'(dut_word), 32'h0);
        tick(); checkOutput("halt_entered", 32'(dut_word), 32'(S_HALTED));
        for (int i = 0; i < 4; i++) begin
            Run = ~Run;
            tick();
            checkOutput("halt_run_toggle", 32'(dut_word), 32'(S_HALTED));
        end

        // Clear in the middle of a fetch wait
        Clear = 1'b1;
        @(negedge Clock);
        Clear     = 1'b0;
        Run       = 1'b1;
        Mem_Ready = 1'b0;
        tick(); tick(); tick();
        checkOutput("pre_clear_T1", 32'(dut_word), 32'(W_FETCH1));
        #2 Clear = 1'b1;
        #1 checkOutput("clear_async", 32'(dut_word), 32'h0);
        @(negedge Clock);
        Clear     = 1'b0;
        Mem_Ready = 1'b1;
        checkOutput("clear_idle", 32'(dut_word), 32'h0);
        tick(); checkOutput("restart_T0", 32'(dut_word), 32'(W_FETCH0));

        // randomized streams against the model
        Clear = 1'b1;
        model_reset();
        repeat (4000) begin
            @(negedge Clock);
            compare_model();
            applyStimulus();
            if (Clear)
                model_reset();
            else
                model_step(Run, Mem_Ready);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
